// File: rtl/anomaly_event_logger_if.sv
// anomaly_event_logger_if
//   Bundles the detector-side sample stream and the record readout handshake
//   of the anomaly event logger.
//   Sample side : in_valid, in_word (bit 0 = label, [N-1:1] = prediction),
//                 in_step, flush.
//   Record side : ev_valid / ev_ready handshake with ev_start, ev_len, ev_peak.
//   modport master : the environment (detector + host) driving samples and
//                    consuming records.
//   modport slave  : the logger itself.
//   N and LEN_W must match the parameters of the logger instance.
interface anomaly_event_logger_if #(
   parameter int N     = 32,
   parameter int LEN_W = 16
);
   logic             in_valid;
   logic [N-1:0]     in_word;
   logic [N-1:0]     in_step;
   logic             flush;
   logic             ev_valid;
   logic             ev_ready;
   logic [N-1:0]     ev_start;
   logic [LEN_W-1:0] ev_len;
   logic [N-1:0]     ev_peak;

   modport master (
      output in_valid, in_word, in_step, flush, ev_ready,
      input  ev_valid, ev_start, ev_len, ev_peak
   );

   modport slave (
      input  in_valid, in_word, in_step, flush, ev_ready,
      output ev_valid, ev_start, ev_len, ev_peak
   );
endinterface

// File: rtl/anomaly_event_logger.sv
// anomaly_event_logger
//   Merges runs of anomalous detector samples (tolerating up to MAX_GAP normal
//   samples inside a run) into event records {start, len, peak}, queues them in
//   a show-ahead FIFO of DEPTH records and hands them out over valid/ready.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     bus         : anomaly_event_logger_if.slave (samples in, records out)
//     fifo_count  : number of records currently held (0..DEPTH)
//     drop_cnt    : records lost because the FIFO was full (saturating)
//     busy        : an event is currently open
module anomaly_event_logger #(
   parameter int N       = 32,
   parameter int DEPTH   = 16,
   parameter int MAX_GAP = 2,
   parameter int LEN_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   anomaly_event_logger_if.slave    bus,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [15:0]              drop_cnt,
   output logic                     busy
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int GAP_W = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);

   localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [GAP_W-1:0] GAP_ZERO  = {GAP_W{1'b0}};
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);
   localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [N-1:0]     start;
      logic [LEN_W-1:0] len;
      logic [N-1:0]     peak;
   } rec_t;

   // Saturating length extension: a pending gap plus the new anomalous sample.
   function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] len,
                                                input logic [GAP_W-1:0] gap);
      logic [LEN_W+GAP_W:0] sum;
      sum = {{(GAP_W+1){1'b0}}, len} + {{(LEN_W+1){1'b0}}, gap}
          + {{(LEN_W+GAP_W){1'b0}}, 1'b1};
      if (sum > {{(GAP_W+1){1'b0}}, LEN_MAX}) begin
         return LEN_MAX;
      end else begin
         return sum[LEN_W-1:0];
      end
   endfunction

   // Signed maximum of two peak candidates.
   function automatic logic [N-1:0] peak_max(input logic [N-1:0] a,
                                             input logic [N-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // Event accumulator and FSM state
   state_t           state_r;
   logic [N-1:0]     start_r;
   logic [LEN_W-1:0] len_r;
   logic [GAP_W-1:0] gap_r;
   logic [N-1:0]     peak_r;
   logic             busy_r;

   // FIFO state and registered head
   rec_t             mem_r [DEPTH];
   logic [AW-1:0]    rd_r;
   logic [AW-1:0]    wr_r;
   logic [CW-1:0]    count_r;
   logic [15:0]      drop_r;
   logic             ev_valid_r;
   rec_t             head_r;

   // Next-state values
   state_t           state_s;
   logic [N-1:0]     start_s;
   logic [LEN_W-1:0] len_s;
   logic [GAP_W-1:0] gap_s;
   logic [N-1:0]     peak_s;
   logic             push_s;
   rec_t             rec_s;

   logic             label_s;
   logic [N-1:0]     sample_s;
   logic             pop_s;
   logic             full_s;
   logic             wr_s;
   logic             drop_s;
   logic             head_from_push_s;
   logic [AW-1:0]    rd_next_s;
   logic [CW-1:0]    count_next_s;

   assign label_s  = bus.in_word[0];
   assign sample_s = {bus.in_word[N-1:1], 1'b0};

   // Folds the current sample into the open event, then applies flush.
   always_comb begin
      state_s = state_r;
      start_s = start_r;
      len_s   = len_r;
      gap_s   = gap_r;
      peak_s  = peak_r;
      push_s  = 1'b0;
      if (bus.in_valid) begin
         case (state_r)
            IDLE: begin
               if (label_s) begin
                  start_s = bus.in_step;
                  len_s   = LEN_ONE;
                  peak_s  = sample_s;
                  gap_s   = GAP_ZERO;
                  state_s = RUN;
               end else begin
                  state_s = IDLE;
               end
            end
            RUN: begin
               if (label_s) begin
                  len_s  = len_add(len_r, GAP_ZERO);
                  peak_s = peak_max(peak_r, sample_s);
               end else if (MAX_GAP == 0) begin
                  push_s  = 1'b1;
                  state_s = IDLE;
               end else begin
                  gap_s   = GAP_ONE;
                  state_s = GAP;
               end
            end
            GAP: begin
               if (label_s) begin
                  // Bridged gap steps become part of the span.
                  len_s   = len_add(len_r, gap_r);
                  peak_s  = peak_max(peak_r, sample_s);
                  gap_s   = GAP_ZERO;
                  state_s = RUN;
               end else if (gap_r == GAP_LIMIT) begin
                  // Trailing normal steps are not part of len.
                  push_s  = 1'b1;
                  state_s = IDLE;
               end else begin
                  gap_s = gap_r + GAP_ONE;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
      // Flush closes whatever is still open after the sample was folded in.
      if (bus.flush && (state_s != IDLE)) begin
         push_s  = 1'b1;
         state_s = IDLE;
      end else begin
         push_s = push_s;
      end
      rec_s = '{start: start_s, len: len_s, peak: peak_s};
   end

   // FIFO bookkeeping: pop/push/drop decisions and next head selection.
   always_comb begin
      pop_s        = ev_valid_r & bus.ev_ready;
      full_s       = (count_r == CNT_FULL);
      wr_s         = push_s & (~full_s | pop_s);
      drop_s       = push_s & full_s & ~pop_s;
      rd_next_s    = rd_r + AW'(pop_s);
      count_next_s = count_r + CW'(wr_s) - CW'(pop_s);
      // The pushed record is the new head when nothing else remains queued.
      head_from_push_s = wr_s & ((count_r == CNT_ZERO) |
                                 ((count_r == CNT_ONE) & pop_s));
   end

   // Record storage; contents only matter while counted as valid.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_r] <= rec_s;
      end else begin
         mem_r[wr_r] <= mem_r[wr_r];
      end
   end

   // Event FSM, FIFO pointers, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         start_r    <= {N{1'b0}};
         len_r      <= {LEN_W{1'b0}};
         gap_r      <= GAP_ZERO;
         peak_r     <= {N{1'b0}};
         busy_r     <= 1'b0;
         rd_r       <= {AW{1'b0}};
         wr_r       <= {AW{1'b0}};
         count_r    <= CNT_ZERO;
         drop_r     <= 16'h0000;
         ev_valid_r <= 1'b0;
         head_r     <= '{start: {N{1'b0}}, len: {LEN_W{1'b0}}, peak: {N{1'b0}}};
      end else begin
         state_r    <= state_s;
         start_r    <= start_s;
         len_r      <= len_s;
         gap_r      <= gap_s;
         peak_r     <= peak_s;
         busy_r     <= (state_s != IDLE);
         rd_r       <= rd_next_s;
         wr_r       <= wr_r + AW'(wr_s);
         count_r    <= count_next_s;
         ev_valid_r <= (count_next_s != CNT_ZERO);
         if (drop_s && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'h0001;
         end else begin
            drop_r <= drop_r;
         end
         // Head holds its last value once the FIFO runs empty.
         if (head_from_push_s) begin
            head_r <= rec_s;
         end else if (count_next_s != CNT_ZERO) begin
            head_r <= mem_r[rd_next_s];
         end else begin
            head_r <= head_r;
         end
      end
   end

   assign bus.ev_valid = ev_valid_r;
   assign bus.ev_start = head_r.start;
   assign bus.ev_len   = head_r.len;
   assign bus.ev_peak  = head_r.peak;
   assign fifo_count   = count_r;
   assign drop_cnt     = drop_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_anomaly_event_logger.sv
// Testbench for anomaly_event_logger (DEPTH=4, MAX_GAP=2, LEN_W=4).
// An event-level model (open event as start / anomalous span / trailing
// normals / peak, records in a queue) predicts every output each cycle;
// directed scenarios add literal expectations.
module tb_anomaly_event_logger;

   localparam int N       = 32;
   localparam int DEPTH   = 4;
   localparam int MAX_GAP = 2;
   localparam int LEN_W   = 4;
   localparam int LMAX    = 15;

   typedef struct packed {
      logic [31:0] start;
      logic [3:0]  len;
      logic [31:0] peak;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  fifo_count;
   logic [15:0] drop_cnt;
   logic        busy;

   anomaly_event_logger_if #(.N(N), .LEN_W(LEN_W)) bus ();

   anomaly_event_logger #(
      .N(N), .DEPTH(DEPTH), .MAX_GAP(MAX_GAP), .LEN_W(LEN_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // model state
   bit                 m_open = 1'b0;
   logic [31:0]        m_start = 32'd0;
   int                 m_span = 0;
   int                 m_trail = 0;
   logic signed [31:0] m_peak = 32'sd0;
   rec_t               q[$];
   rec_t               hd = '0;
   int                 m_drop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      rec_t        r;
      bit          close_now;
      bit          pop;
      bit          full_before;
      logic [31:0] smp;
      if (reset) begin
         q.delete();
         hd     = '0;
         m_drop = 0;
         m_open = 1'b0;
         return;
      end
      close_now = 1'b0;
      r         = '0;
      pop       = (q.size() != 0) && bus.ev_ready;
      smp       = {bus.in_word[31:1], 1'b0};
      if (bus.in_valid) begin
         if (bus.in_word[0]) begin
            if (!m_open) begin
               m_open  = 1'b1;
               m_start = bus.in_step;
               m_span  = 1;
               m_trail = 0;
               m_peak  = smp;
            end else begin
               m_span  = m_span + m_trail + 1;
               m_trail = 0;
               if ($signed(smp) > m_peak) m_peak = smp;
            end
         end else if (m_open) begin
            m_trail++;
            if (m_trail > MAX_GAP) close_now = 1'b1;
         end
      end
      if (bus.flush && m_open) close_now = 1'b1;
      if (close_now) begin
         r.start = m_start;
         r.len   = 4'((m_span > LMAX) ? LMAX : m_span);
         r.peak  = m_peak;
         m_open  = 1'b0;
      end
      full_before = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (close_now) begin
         if (full_before && !pop) begin
            if (m_drop < 65535) m_drop++;
         end else begin
            q.push_back(r);
         end
      end
      if (q.size() != 0) hd = q[0];
   endtask

   task automatic compare();
      chk("ev_valid",   32'(bus.ev_valid), 32'(q.size() != 0));
      chk("ev_start",   bus.ev_start,      hd.start);
      chk("ev_len",     32'(bus.ev_len),   32'(hd.len));
      chk("ev_peak",    bus.ev_peak,       hd.peak);
      chk("fifo_count", 32'(fifo_count),   32'(q.size()));
      chk("drop_cnt",   32'(drop_cnt),     32'(m_drop));
      chk("busy",       32'(busy),         32'(m_open));
   endtask

   task automatic step(input bit v, input bit lab, input logic [30:0] pred,
                       input logic [31:0] stp, input bit fl);
      bus.in_valid = v;
      bus.in_word  = {pred, lab};
      bus.in_step  = stp;
      bus.flush    = fl;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 31'd0, 32'd0, 1'b0);
   endtask

   initial begin
      bit          lab7 [7];
      bit          lab5 [5];
      logic [30:0] pred;
      int          best;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_word  = 32'd0;
      bus.in_step  = 32'd0;
      bus.flush    = 1'b0;
      bus.ev_ready = 1'b1;
      idle();
      idle();
      reset = 1'b0;
      chk("rst_valid", 32'(bus.ev_valid), 32'd0);
      chk("rst_count", 32'(fifo_count),   32'd0);
      chk("rst_busy",  32'(busy),         32'd0);
      idle();

      // simple run 101..103 closed by three normals
      lab7 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         pred = (i == 1) ? 31'd5 : (i == 2) ? 31'd9 : (i == 3) ? 31'd7 : 31'd40;
         step(1'b1, lab7[i], pred, 32'(100 + i), 1'b0);
         if (i == 5) chk("t1_not_early", 32'(bus.ev_valid), 32'd0);
      end
      chk("t1_valid", 32'(bus.ev_valid), 32'd1);
      chk("t1_start", bus.ev_start,      32'd101);
      chk("t1_len",   32'(bus.ev_len),   32'd3);
      chk("t1_peak",  bus.ev_peak,       32'd18);
      idle();
      chk("t1_popped", 32'(bus.ev_valid), 32'd0);

      // gap of two normals merged
      lab7 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         pred = (i == 0) ? 31'd3 : (i == 3) ? 31'd4 : 31'd60;
         step(1'b1, lab7[i], pred, 32'(10 + i), 1'b0);
      end
      chk("t2_start", bus.ev_start,    32'd10);
      chk("t2_len",   32'(bus.ev_len), 32'd4);
      chk("t2_peak",  bus.ev_peak,     32'd8);
      idle();

      // gap of three normals splits into two events
      lab5 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         pred = (i == 0) ? 31'd1 : (i == 4) ? 31'd2 : 31'd70;
         step(1'b1, lab5[i], pred, 32'(10 + i), 1'b0);
         if (i == 3) begin
            chk("t2b_start", bus.ev_start,    32'd10);
            chk("t2b_len",   32'(bus.ev_len), 32'd1);
         end
      end
      chk("t2b_open", 32'(busy), 32'd1);
      step(1'b0, 1'b0, 31'd0, 32'd0, 1'b1);
      chk("t2c_start", bus.ev_start,    32'd14);
      chk("t2c_len",   32'(bus.ev_len), 32'd1);
      chk("t2c_peak",  bus.ev_peak,     32'd4);

      // negative predictions: signed peak
      step(1'b1, 1'b1, 31'h7FFF_FFFF, 32'd200, 1'b0);
      step(1'b1, 1'b1, 31'h7FFF_FFFE, 32'd201, 1'b1);
      chk("neg_len",  32'(bus.ev_len), 32'd2);
      chk("neg_peak", bus.ev_peak,     32'hFFFF_FFFE);
      idle();

      // anomaly + flush in IDLE, then flush alone
      step(1'b1, 1'b1, 31'd6, 32'd50, 1'b1);
      chk("t3_valid", 32'(bus.ev_valid), 32'd1);
      chk("t3_start", bus.ev_start,      32'd50);
      chk("t3_len",   32'(bus.ev_len),   32'd1);
      chk("t3_busy",  32'(busy),         32'd0);
      step(1'b0, 1'b0, 31'd0, 32'd0, 1'b1);
      idle();
      chk("t3_norec", 32'(fifo_count), 32'd0);

      // overflow with consumer stalled
      bus.ev_ready = 1'b0;
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 31'(k + 1), 32'(300 + k), 1'b1);
      chk("t4_count", 32'(fifo_count), 32'd4);
      chk("t4_drop",  32'(drop_cnt),   32'd2);
      chk("t4_head",  bus.ev_start,    32'd300);
      idle();
      chk("t4_stable", bus.ev_start, 32'd300);
      bus.ev_ready = 1'b1;
      step(1'b1, 1'b1, 31'd9, 32'd400, 1'b1);
      chk("t4_fullpp_count", 32'(fifo_count), 32'd4);
      chk("t4_fullpp_drop",  32'(drop_cnt),   32'd2);
      chk("t4_head1",        bus.ev_start,    32'd301);
      idle();
      chk("t4_head2", bus.ev_start, 32'd302);
      idle();
      chk("t4_head3", bus.ev_start, 32'd303);
      idle();
      chk("t4_head4", bus.ev_start, 32'd400);
      idle();
      chk("t4_empty", 32'(bus.ev_valid), 32'd0);
      chk("t4_hold",  bus.ev_start,      32'd400);

      // reset while in GAP with three records queued
      bus.ev_ready = 1'b0;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 31'd2, 32'(450 + k), 1'b1);
      step(1'b1, 1'b1, 31'd8, 32'd500, 1'b0);
      step(1'b1, 1'b0, 31'd0, 32'd501, 1'b0);
      chk("t5_pre_count", 32'(fifo_count), 32'd3);
      chk("t5_pre_busy",  32'(busy),       32'd1);
      reset = 1'b1;
      idle();
      reset = 1'b0;
      chk("t5_valid", 32'(bus.ev_valid), 32'd0);
      chk("t5_count", 32'(fifo_count),   32'd0);
      chk("t5_busy",  32'(busy),         32'd0);
      chk("t5_drop",  32'(drop_cnt),     32'd0);
      step(1'b1, 1'b1, 31'd3, 32'd600, 1'b1);
      chk("t5_new_start", bus.ev_start,    32'd600);
      chk("t5_new_len",   32'(bus.ev_len), 32'd1);
      bus.ev_ready = 1'b1;
      idle();

      // length saturation at 15 over 20 anomalies
      best = 0;
      for (int i = 0; i < 20; i++) begin
         pred = 31'((i * 37) % 50);
         if (int'(pred) > best) best = int'(pred);
         step(1'b1, 1'b1, pred, 32'(700 + i), 1'b0);
      end
      chk("t6_busy", 32'(busy), 32'd1);
      step(1'b0, 1'b0, 31'd0, 32'd0, 1'b1);
      chk("t6_start", bus.ev_start,    32'd700);
      chk("t6_len",   32'(bus.ev_len), 32'd15);
      chk("t6_peak",  bus.ev_peak,     32'd96);
      chk("t6_peak_model", bus.ev_peak, 32'(best * 2));
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
